// File: rtl/row_sched_ctrl.sv
// row_sched_ctrl: row-processing sequencer in front of mem_controller.
// Issues the mem_controller start pulse, waits for the per-row valid strobe,
// models PE compute time (activation-serial or weight-serial), and returns
// row_finish_done_0 / row_cal_done for every row before signalling completion.
// Optional build macro: ROW_SCHED_WATCHDOG_EN adds a WAIT_EN watchdog and an
// en protocol check that raise the sticky o_sched_err and abort to IDLE.
module row_sched_ctrl #(
  parameter int NUM_ROWS_W = 5,
  parameter int ACT_W      = 5,
  parameter int WEI_W      = 4,
  parameter int MAC_LAT    = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_sched_start,
  input  logic                  i_cfg_mode,
  input  logic [NUM_ROWS_W-1:0] i_cfg_rows,
  input  logic                  i_soft_clear,
  input  logic                  i_row_stall,
  input  logic                  i_en,
  input  logic [ACT_W-1:0]      i_row_val_num,
  input  logic [WEI_W-1:0]      i_wei_val_num,
  input  logic                  i_zero_flag,
  output logic                  o_mc_start,
  output logic                  o_mode,
  output logic                  o_row_finish_done_0,
  output logic                  o_row_cal_done,
  output logic [NUM_ROWS_W-1:0] o_row_cnt,
  output logic                  o_busy,
  output logic                  o_sched_done,
  output logic                  o_sched_err
);

  localparam int REM_W = (ACT_W > WEI_W) ? ACT_W : WEI_W;
  localparam int SUB_W = $clog2(MAC_LAT + 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LAUNCH  = 3'd1;
  localparam logic [2:0] S_WAIT_EN = 3'd2;
  localparam logic [2:0] S_RUN     = 3'd3;
  localparam logic [2:0] S_FIN     = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  logic [2:0]            r_state;
  logic                  r_mode;
  logic [NUM_ROWS_W-1:0] r_rows;
  logic [NUM_ROWS_W-1:0] r_row_cnt;
  logic [REM_W-1:0]      r_rem;
  logic [SUB_W-1:0]      r_sub;

  logic             w_step;
  logic             w_sub_last;
  logic             w_rem_last;
  logic             w_mid_pulse;
  logic [REM_W-1:0] w_load;
  logic             w_wd_trip;

  // A RUN cycle only advances the work counters when not stalled; a lone
  // pass-finish pulse fires on the unstalled cycle where the MAC timer expires
  // with more weights still to go.
  assign w_step      = (r_state == S_RUN) && !i_row_stall;
  assign w_sub_last  = (r_sub == SUB_W'(1));
  assign w_rem_last  = (r_rem == REM_W'(1));
  assign w_mid_pulse = w_step && r_mode && w_sub_last && !w_rem_last;
  assign w_load      = r_mode ? REM_W'(i_wei_val_num) : REM_W'(i_row_val_num);

`ifdef ROW_SCHED_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);

  logic [WD_W-1:0] r_wd;
  logic            r_err;
  logic            w_timeout;
  logic            w_viol;

  assign w_timeout = (r_state == S_WAIT_EN) && !i_en && (r_wd == WD_W'(TIMEOUT - 1));
  assign w_viol    = i_en && (r_state != S_WAIT_EN);
  assign w_wd_trip = w_timeout || w_viol;

  // Count consecutive WAIT_EN cycles that have not yet seen en
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wd <= '0;
    end else if (i_soft_clear || (r_state != S_WAIT_EN) || i_en) begin
      r_wd <= '0;
    end else begin
      r_wd <= r_wd + 1'b1;
    end
  end

  // Sticky error flag, cleared only by reset or soft_clear
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_err <= 1'b0;
    end else if (i_soft_clear) begin
      r_err <= 1'b0;
    end else if (w_wd_trip) begin
      r_err <= 1'b1;
    end
  end

  assign o_sched_err = r_err;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT == 0);
  assign w_wd_trip   = 1'b0;
  assign o_sched_err = 1'b0;
`endif

  // Main sequencer: launch, per-row wait/compute/finish, completion
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_mode    <= 1'b0;
      r_rows    <= '0;
      r_row_cnt <= '0;
      r_rem     <= '0;
      r_sub     <= '0;
    end else if (i_soft_clear) begin
      r_state <= S_IDLE;
      r_rem   <= '0;
      r_sub   <= '0;
    end else if (w_wd_trip) begin
      r_state <= S_IDLE;
      r_rem   <= '0;
      r_sub   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_sched_start) begin
            r_mode    <= i_cfg_mode;
            r_rows    <= i_cfg_rows;
            r_row_cnt <= '0;
            r_state   <= (i_cfg_rows == '0) ? S_DONE : S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          r_state <= S_WAIT_EN;
        end
        S_WAIT_EN: begin
          if (i_en) begin
            r_rem   <= w_load;
            r_sub   <= SUB_W'(MAC_LAT);
            r_state <= (i_zero_flag || (w_load == '0)) ? S_FIN : S_RUN;
          end
        end
        S_RUN: begin
          if (w_step) begin
            if (!r_mode) begin
              r_rem <= r_rem - 1'b1;
              if (w_rem_last) begin
                r_state <= S_FIN;
              end
            end else if (w_sub_last) begin
              if (w_rem_last) begin
                r_sub   <= '0;
                r_state <= S_FIN;
              end else begin
                r_rem <= r_rem - 1'b1;
                r_sub <= SUB_W'(MAC_LAT);
              end
            end else begin
              r_sub <= r_sub - 1'b1;
            end
          end
        end
        S_FIN: begin
          r_row_cnt <= r_row_cnt + 1'b1;
          r_state   <= ((r_row_cnt + 1'b1) == r_rows) ? S_DONE : S_WAIT_EN;
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Pulse outputs decode the current state; soft_clear or an abort masks them
  assign o_mc_start          = (r_state == S_LAUNCH) && !i_soft_clear && !w_wd_trip;
  assign o_row_cal_done      = (r_state == S_FIN) && !i_soft_clear && !w_wd_trip;
  assign o_row_finish_done_0 = ((r_state == S_FIN) || w_mid_pulse) && !i_soft_clear && !w_wd_trip;
  assign o_sched_done        = (r_state == S_DONE) && !i_soft_clear && !w_wd_trip;
  assign o_busy              = (r_state != S_IDLE);
  assign o_mode              = r_mode;
  assign o_row_cnt           = r_row_cnt;

endmodule

// File: tb/tb_row_sched_ctrl.sv
// Directed testbench for row_sched_ctrl. Pulse outputs are logged with the
// cycle number they occurred in and compared against hand-computed cycles.
module tb_row_sched_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sched_start;
  logic       cfg_mode;
  logic [4:0] cfg_rows;
  logic       soft_clear;
  logic       row_stall;
  logic       en;
  logic [4:0] row_val_num;
  logic [3:0] wei_val_num;
  logic       zero_flag;
  logic       mc_start;
  logic       mode;
  logic       row_finish_done_0;
  logic       row_cal_done;
  logic [4:0] row_cnt;
  logic       busy;
  logic       sched_done;
  logic       sched_err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int fin_q[$];
  int cal_q[$];
  int done_q[$];
  int mcs_q[$];
  int exp_q[$];
  int e0, e1, e2, e3, t0;

  row_sched_ctrl #(
    .NUM_ROWS_W(5), .ACT_W(5), .WEI_W(4), .MAC_LAT(4), .TIMEOUT(255)
  ) dut (
    .i_clk              (clk),
    .i_rst_n            (rst_n),
    .i_sched_start      (sched_start),
    .i_cfg_mode         (cfg_mode),
    .i_cfg_rows         (cfg_rows),
    .i_soft_clear       (soft_clear),
    .i_row_stall        (row_stall),
    .i_en               (en),
    .i_row_val_num      (row_val_num),
    .i_wei_val_num      (wei_val_num),
    .i_zero_flag        (zero_flag),
    .o_mc_start         (mc_start),
    .o_mode             (mode),
    .o_row_finish_done_0(row_finish_done_0),
    .o_row_cal_done     (row_cal_done),
    .o_row_cnt          (row_cnt),
    .o_busy             (busy),
    .o_sched_done       (sched_done),
    .o_sched_err        (sched_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Log every pulse with the cycle it was observed in (mid-cycle sample)
  always @(negedge clk) begin
    if (row_finish_done_0 === 1'b1) fin_q.push_back(cyc);
    if (row_cal_done === 1'b1)      cal_q.push_back(cyc);
    if (sched_done === 1'b1)        done_q.push_back(cyc);
    if (mc_start === 1'b1)          mcs_q.push_back(cyc);
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: observed no end expected end");
    $fatal(1, "simulation time limit");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
    $display("check %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic chk_q(input string tag, input int obs[$], input int exp[$]);
    chk({tag, "_count"}, obs.size(), exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      chk($sformatf("%s_%0d", tag, i), (i < obs.size()) ? obs[i] : -1, exp[i]);
    end
  endtask

  task automatic clear_q();
    fin_q.delete();
    cal_q.delete();
    done_q.delete();
    mcs_q.delete();
  endtask

  task automatic launch(input logic m, input logic [4:0] rows, output int t);
    cfg_mode    = m;
    cfg_rows    = rows;
    sched_start = 1'b1;
    t           = cyc;
    tick();
    sched_start = 1'b0;
    tick();
  endtask

  // Present one row, then wait (bounded) for row_cal_done; stall is raised
  // for cycles en+lo .. en+hi-1. Returns in the cycle after row_cal_done.
  task automatic run_row(input logic [4:0] av, input logic [3:0] wv, input logic zf,
                         input int lo, input int hi, output int en_cyc);
    bit seen;
    seen        = 1'b0;
    en          = 1'b1;
    row_val_num = av;
    wei_val_num = wv;
    zero_flag   = zf;
    en_cyc      = cyc;
    tick();
    en          = 1'b0;
    row_val_num = '0;
    wei_val_num = '0;
    zero_flag   = 1'b0;
    for (int i = 0; i < 300; i++) begin
      row_stall = ((cyc - en_cyc) >= lo) && ((cyc - en_cyc) < hi);
      @(negedge clk);
      if (row_cal_done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    row_stall = 1'b0;
    if (!seen) chk("row_wait_timeout", 0, 1);
    tick();
  endtask

  initial begin
    rst_n       = 1'b0;
    sched_start = 1'b1;
    cfg_mode    = 1'b1;
    cfg_rows    = 5'd3;
    soft_clear  = 1'b0;
    row_stall   = 1'b0;
    en          = 1'b0;
    row_val_num = '0;
    wei_val_num = '0;
    zero_flag   = 1'b0;

    // Reset state (sched_start held high must not launch anything)
    repeat (3) tick();
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_mc_start", mc_start, 0);
    chk("rst_mode", mode, 0);
    chk("rst_row_cnt", row_cnt, 0);
    chk("rst_cal_done", row_cal_done, 0);
    chk("rst_finish", row_finish_done_0, 0);
    chk("rst_sched_done", sched_done, 0);
    chk("rst_sched_err", sched_err, 0);
    tick();
    sched_start = 1'b0;
    rst_n       = 1'b1;
    tick();

    // Mode 0, 4 rows: cal/finish at en + row_val_num + 1
    clear_q();
    launch(1'b0, 5'd4, t0);
    run_row(5'd7, 4'd3, 1'b0, 0, 0, e0);
    run_row(5'd4, 4'd3, 1'b0, 0, 0, e1);
    run_row(5'd5, 4'd3, 1'b0, 0, 0, e2);
    run_row(5'd2, 4'd3, 1'b0, 0, 0, e3);
    repeat (3) tick();
    @(negedge clk);
    chk("m0_row_cnt", row_cnt, 4);
    chk("m0_busy_after", busy, 0);
    exp_q = '{t0 + 1};
    chk_q("m0_mc_start", mcs_q, exp_q);
    exp_q = '{e0 + 8, e1 + 5, e2 + 6, e3 + 3};
    chk_q("m0_cal", cal_q, exp_q);
    chk_q("m0_fin", fin_q, exp_q);
    exp_q = '{e3 + 4};
    chk_q("m0_done", done_q, exp_q);
    tick();

    // Mode 1, 3 rows, weights 1,0,2 (row_val_num nonzero but unused)
    clear_q();
    launch(1'b1, 5'd3, t0);
    @(negedge clk);
    chk("m1_mode", mode, 1);
    chk("m1_busy", busy, 1);
    tick();
    run_row(5'd7, 4'd1, 1'b0, 0, 0, e0);
    run_row(5'd7, 4'd0, 1'b0, 0, 0, e1);
    run_row(5'd7, 4'd2, 1'b0, 0, 0, e2);
    repeat (3) tick();
    @(negedge clk);
    chk("m1_row_cnt", row_cnt, 3);
    exp_q = '{e0 + 5, e1 + 1, e2 + 4, e2 + 9};
    chk_q("m1_fin", fin_q, exp_q);
    exp_q = '{e0 + 5, e1 + 1, e2 + 9};
    chk_q("m1_cal", cal_q, exp_q);
    exp_q = '{e2 + 10};
    chk_q("m1_done", done_q, exp_q);
    tick();

    // Mode 1, 3 weights, stall during en+2..en+4 shifts every pulse by 3
    clear_q();
    launch(1'b1, 5'd1, t0);
    run_row(5'd0, 4'd3, 1'b0, 2, 5, e0);
    repeat (3) tick();
    @(negedge clk);
    exp_q = '{e0 + 7, e0 + 11, e0 + 16};
    chk_q("stall_fin", fin_q, exp_q);
    exp_q = '{e0 + 16};
    chk_q("stall_cal", cal_q, exp_q);
    exp_q = '{e0 + 17};
    chk_q("stall_done", done_q, exp_q);
    tick();

    // cfg_rows = 0: straight to DONE; second start while busy is dropped
    clear_q();
    cfg_mode    = 1'b0;
    cfg_rows    = 5'd0;
    sched_start = 1'b1;
    t0          = cyc;
    tick();
    cfg_rows = 5'd2;
    @(negedge clk);
    chk("zr_sched_done", sched_done, 1);
    chk("zr_busy", busy, 1);
    chk("zr_mc_start", mc_start, 0);
    tick();
    sched_start = 1'b0;
    @(negedge clk);
    chk("zr_idle_busy", busy, 0);
    repeat (3) tick();
    @(negedge clk);
    chk("zr_mc_count", mcs_q.size(), 0);
    exp_q = '{t0 + 1};
    chk_q("zr_done", done_q, exp_q);
    tick();

    // soft_clear mid-RUN of row 1; row 0 is a zero-flag row (1 cycle)
    clear_q();
    launch(1'b0, 5'd3, t0);
    run_row(5'd5, 4'd0, 1'b1, 0, 0, e0);
    en          = 1'b1;
    row_val_num = 5'd6;
    e1          = cyc;
    tick();
    en          = 1'b0;
    row_val_num = '0;
    tick();
    tick();
    soft_clear = 1'b1;
    @(negedge clk);
    chk("sc_busy_during", busy, 1);
    tick();
    soft_clear = 1'b0;
    @(negedge clk);
    chk("sc_busy_after", busy, 0);
    chk("sc_row_cnt_hold", row_cnt, 1);
    repeat (10) tick();
    @(negedge clk);
    exp_q = '{e0 + 1};
    chk_q("sc_cal", cal_q, exp_q);
    chk_q("sc_fin", fin_q, exp_q);
    chk("sc_done_count", done_q.size(), 0);
    tick();
    // relaunch clears row_cnt
    cfg_rows    = 5'd2;
    sched_start = 1'b1;
    tick();
    sched_start = 1'b0;
    @(negedge clk);
    chk("sc_relaunch_row_cnt", row_cnt, 0);
    chk("sc_relaunch_mc_start", mc_start, 1);
    tick();
    soft_clear = 1'b1;
    tick();
    soft_clear = 1'b0;
    // start and clear together: clear wins
    sched_start = 1'b1;
    soft_clear  = 1'b1;
    tick();
    sched_start = 1'b0;
    soft_clear  = 1'b0;
    @(negedge clk);
    chk("sc_start_vs_clear_busy", busy, 0);
    chk("sc_start_vs_clear_mc", mc_start, 0);
    tick();

    // No en after launch: watchdog aborts, otherwise waits forever
    clear_q();
    launch(1'b0, 5'd1, t0);
    repeat (300) tick();
    @(negedge clk);
`ifdef ROW_SCHED_WATCHDOG_EN
    chk("wd_err", sched_err, 1);
    chk("wd_busy", busy, 0);
    chk("wd_done_count", done_q.size(), 0);
`else
    chk("wd_err", sched_err, 0);
    chk("wd_busy", busy, 1);
`endif
    tick();
    soft_clear = 1'b1;
    tick();
    soft_clear = 1'b0;
    @(negedge clk);
    chk("wd_clear_err", sched_err, 0);
    chk("wd_clear_busy", busy, 0);
    tick();

    // Asynchronous reset mid-RUN aborts at once with no pulses
    clear_q();
    launch(1'b0, 5'd2, t0);
    en          = 1'b1;
    row_val_num = 5'd9;
    tick();
    en          = 1'b0;
    row_val_num = '0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    tick();
    rst_n = 1'b1;
    repeat (12) tick();
    @(negedge clk);
    chk("arst_cal_count", cal_q.size(), 0);
    chk("arst_busy_after", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
